// File: rtl/freq_meter_pkg.sv
// Shared definitions for the gated frequency meter: FSM encoding and
// gate-counter sizing.
package freq_meter_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_COUNT = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_COUNT = ST_COUNT
    } state_t;

    // Width of a counter that must reach gate_cycles-1; never narrower than 1 bit.
    function automatic int gate_cnt_width(input int gate_cycles);
        return (gate_cycles <= 2) ? 1 : $clog2(gate_cycles);
    endfunction

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Two-flop synchronizer plus delay flop; emits a one-cycle pulse on each
// synchronized rising edge of an asynchronous input.
module edge_sync (
    input  logic clk_in,
    input  logic rst_n,
    input  logic sig_in,
    output logic sig_edge
);
    import freq_meter_pkg::*;

    logic sync_p0;
    logic sync_p1;
    logic sync_p2;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= sig_in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign sig_edge = sync_p1 & ~sync_p2;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a
// window of gateCycles clocks, single-shot or back-to-back.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int clkInFreq  = 1_000_000,
    parameter int gateCycles = 1_000_000,
    parameter int cntWidth   = 16
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                sig_in,
    input  logic                start,
    input  logic                cont,
    output logic                busy,
    output logic [cntWidth-1:0] freq_out,
    output logic                ovf,
    output logic                valid
);
    localparam int                  GATE_W    = gate_cnt_width(gateCycles);
    localparam logic [GATE_W-1:0]   GATE_LAST = GATE_W'(gateCycles - 1);
    localparam logic [cntWidth-1:0] CNT_MAX   = '1;

    if (gateCycles < 2) begin : g_bad_gate
        $error("freq_meter: gateCycles must be at least 2");
    end
    if (clkInFreq <= 0) begin : g_bad_freq
        $error("freq_meter: clkInFreq must be positive");
    end

    function automatic logic [cntWidth-1:0] sat_inc(input logic [cntWidth-1:0] cnt,
                                                    input logic inc);
        return (inc && cnt != CNT_MAX) ? cnt + 1'b1 : cnt;
    endfunction

    function automatic logic sat_hit(input logic [cntWidth-1:0] cnt, input logic inc);
        return inc && (cnt == CNT_MAX);
    endfunction

    state_t              state;
    state_t              state_next;
    logic [GATE_W-1:0]   gate_cnt;
    logic [cntWidth-1:0] edge_cnt;
    logic                win_ovf;
    logic                sig_edge;
    logic                gate_end;
    logic [cntWidth-1:0] cnt_next;
    logic                ovf_next;

    edge_sync u_sync (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .sig_in   (sig_in),
        .sig_edge (sig_edge)
    );

    assign busy     = (state == S_COUNT);
    assign gate_end = busy && (gate_cnt == GATE_LAST);
    assign cnt_next = sat_inc(edge_cnt, sig_edge);
    assign ovf_next = win_ovf | sat_hit(edge_cnt, sig_edge);

    always_ff @(posedge clk_in) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start || cont)    state_next = S_COUNT;
            S_COUNT: if (gate_end && !cont) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Counters run only inside a window; IDLE and every gate end clear them so
    // a back-to-back window starts counting on the very next cycle.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            win_ovf  <= 1'b0;
            freq_out <= '0;
            ovf      <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (busy && !gate_end) begin
                gate_cnt <= gate_cnt + 1'b1;
                edge_cnt <= cnt_next;
                win_ovf  <= ovf_next;
            end else begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                win_ovf  <= 1'b0;
            end
            if (gate_end) begin
                freq_out <= cnt_next;
                ovf      <= ovf_next;
                valid    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (16-bit and 4-bit counters) share one
// stimulus stream and are compared every cycle against a window-level model.
module tb_freq_meter;
    localparam int GATE = 1000;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic        sig_in = 1'b0;
    logic        start  = 1'b0;
    logic        cont   = 1'b0;
    logic        busy_a, valid_a, ovf_a;
    logic [15:0] freq_a;
    logic        busy_b, valid_b, ovf_b;
    logic [3:0]  freq_b;

    always #5 clk_in = ~clk_in;

    freq_meter #(.clkInFreq(1_000_000), .gateCycles(GATE), .cntWidth(16)) dut_a (
        .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .start(start), .cont(cont),
        .busy(busy_a), .freq_out(freq_a), .ovf(ovf_a), .valid(valid_a));

    freq_meter #(.clkInFreq(1_000_000), .gateCycles(GATE), .cntWidth(4)) dut_b (
        .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .start(start), .cont(cont),
        .busy(busy_b), .freq_out(freq_b), .ovf(ovf_b), .valid(valid_b));

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    bit hist [0:65535];
    bit m_init = 0, m_busy = 0, m_valid = 0;
    bit m_ovf_a = 0, m_ovf_b = 0;
    int m_begin = 0, m_freq_a = 0, m_freq_b = 0;

    function automatic int count_edges(input int b, input int e);
        int n = 0;
        for (int t = b; t <= e; t++)
            if (t >= 3 && hist[t-2] && !hist[t-3]) n++;
        return n;
    endfunction

    always @(posedge clk_in) begin
        int n;
        hist[cyc] = rst_n ? sig_in : 1'b0;
        m_valid = 0;
        if (!rst_n) begin
            m_init = 1; m_busy = 0;
            m_freq_a = 0; m_freq_b = 0; m_ovf_a = 0; m_ovf_b = 0;
        end else if (!m_busy) begin
            if (start || cont) begin
                m_busy = 1;
                m_begin = cyc + 1;
            end
        end else if (cyc == m_begin + GATE - 1) begin
            n = count_edges(m_begin, cyc);
            m_freq_a = (n > 65535) ? 65535 : n;
            m_ovf_a  = (n > 65535);
            m_freq_b = (n > 15) ? 15 : n;
            m_ovf_b  = (n > 15);
            m_valid  = 1;
            if (cont) m_begin = cyc + 1;
            else      m_busy = 0;
        end
        cyc++;
    end

    // ---------------- per-cycle compare and monitor ----------------
    int va_cnt = 0, va_cyc = 0, va_sum = 0, busy_cnt = 0;
    int va_freq_a = 0, va_freq_b = 0;
    bit va_ovf_a = 0, va_ovf_b = 0;

    always @(negedge clk_in) begin
        if (m_init) begin
            chk("busy_a",  busy_a,  m_busy);
            chk("valid_a", valid_a, m_valid);
            chk("freq_a",  freq_a,  m_freq_a);
            chk("ovf_a",   ovf_a,   m_ovf_a);
            chk("busy_b",  busy_b,  m_busy);
            chk("valid_b", valid_b, m_valid);
            chk("freq_b",  freq_b,  m_freq_b);
            chk("ovf_b",   ovf_b,   m_ovf_b);
        end
        if (valid_a === 1'b1) begin
            va_cnt++;
            va_cyc = cyc;
            va_freq_a = freq_a; va_freq_b = freq_b;
            va_ovf_a = ovf_a;   va_ovf_b = ovf_b;
            va_sum += freq_a;
        end
        if (busy_a === 1'b1) busy_cnt++;
    end

    // ---------------- sig_in generator ----------------
    int sig_mode = 0, sig_per = 10, sig_ph = 0;
    bit sig_level = 0;

    always begin
        @(posedge clk_in);
        #1;
        case (sig_mode)
            0: begin
                sig_ph = (sig_ph + 1) % sig_per;
                sig_in = (sig_ph < sig_per / 2);
            end
            1:       sig_in = sig_level;
            default: sig_in = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- directed and random scenarios ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic pulse_start(output int s0);
        s0 = cyc;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic clear_mon;
        va_cnt = 0; va_sum = 0; busy_cnt = 0;
    endtask

    initial begin
        int s0;
        tick(3);
        rst_n = 1'b1;

        // basic count, period 10
        tick(5 + $urandom_range(0, 9));
        clear_mon();
        pulse_start(s0);
        tick(1005);
        chk("basic_valids", va_cnt, 1);
        chk("basic_valid_cycle", va_cyc - s0, 1001);
        chk("basic_freq", va_freq_a, 100);
        chk("basic_model_freq", m_freq_a, 100);
        chk("basic_ovf", va_ovf_a, 0);
        chk("basic_busy_cycles", busy_cnt, 1000);

        // saturation, period 4
        sig_per = 4;
        tick(20 + $urandom_range(0, 3));
        clear_mon();
        pulse_start(s0);
        tick(1005);
        chk("sat_freq_b", va_freq_b, 15);
        chk("sat_ovf_b", va_ovf_b, 1);
        chk("sat_freq_a", va_freq_a, 250);
        chk("sat_ovf_a", va_ovf_a, 0);

        // continuous, period 20
        sig_per = 20;
        tick(40 + $urandom_range(0, 19));
        clear_mon();
        s0 = cyc;
        cont = 1'b1;
        tick(2501);
        cont = 1'b0;
        tick(600);
        chk("cont_valids", va_cnt, 3);
        chk("cont_freq_sum", va_sum, 150);
        chk("cont_last_freq", va_freq_a, 50);
        chk("cont_last_cycle", va_cyc - s0, 3001);
        chk("cont_busy_cycles", busy_cnt, 3000);
        chk("cont_idle_busy", busy_a, 0);

        // reset mid-window, then a clean measurement
        sig_per = 10;
        tick(30);
        clear_mon();
        pulse_start(s0);
        tick(499);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1100);
        chk("rst_valids", va_cnt, 0);
        chk("rst_freq", freq_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_busy", busy_a, 0);
        clear_mon();
        pulse_start(s0);
        tick(1005);
        chk("rst_after_freq", va_freq_a, 100);
        chk("rst_after_valids", va_cnt, 1);

        // second start mid-window is ignored
        tick(10);
        clear_mon();
        pulse_start(s0);
        tick(299);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(705);
        chk("ign_valid_cycle", va_cyc - s0, 1001);
        chk("ign_freq", va_freq_a, 100);
        tick(1100);
        chk("ign_valids", va_cnt, 1);

        // no activity: sig_in held high
        sig_mode = 1; sig_level = 1;
        tick(20);
        clear_mon();
        pulse_start(s0);
        tick(1005);
        chk("idle_sig_valids", va_cnt, 1);
        chk("idle_sig_valid_cycle", va_cyc - s0, 1001);
        chk("idle_sig_freq", va_freq_a, 0);
        chk("idle_sig_ovf", va_ovf_a, 0);

        // randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 8000; i++) begin
            if (i % 500 == 0) begin
                sig_mode = ($urandom_range(0, 2) == 0) ? 2 : 0;
                sig_per  = $urandom_range(2, 30);
            end
            start = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 999) == 0) cont = ~cont;
            rst_n = ($urandom_range(0, 2999) != 0);
            tick(1);
        end
        start = 1'b0; cont = 1'b0; rst_n = 1'b1;
        tick(1100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
